// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multiport register file.
// Used by regfile_multiport and regfile_scoreboard.
package regfile_pkg;

    localparam int ZERO_REG     = 0;
    localparam int DEFAULT_SIZE = 32;
    localparam int MAX_REGS     = 256;

    typedef logic [$clog2(DEFAULT_SIZE)-1:0] reg_addr_t;

    function automatic int calc_addr_w(input int size);
        return $clog2(size);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on reserve, cleared on write-back.
// Latency: busy bits update on the clock edge; busy_count is combinational.
// Backpressure: none; every reserve and release is accepted.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int SIZE        = 32,
    parameter int WRITE_PORTS = 1,
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WRITE_PORTS-1:0]        wr_en,
    input  logic [WRITE_PORTS*ADDR_W-1:0] wr_addr,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic [SIZE-1:0]               busy_vec,
    output logic [CNT_W-1:0]              busy_count
);

    logic [SIZE-1:1]     busy_q;
    logic [SIZE-1:1]     busy_d;
    logic [MAX_REGS-1:0] busy_ext;

    // Release is applied first so a same-cycle reserve of the same register wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < SIZE; i++) begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = {busy_q, 1'b0};

    always_comb begin
        busy_ext             = '0;
        busy_ext[SIZE-1:0]   = busy_vec;
        busy_count           = CNT_W'(popcount(busy_ext));
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with x0 hardwired to zero and a busy scoreboard.
// Latency: reads combinational, writes visible next cycle (same cycle with REGFILE_WRITE_BYPASS_EN).
// Backpressure: none; all reads, writes and reserves complete unconditionally.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WORDSIZE    = 64,
    parameter int SIZE        = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int ADDR_W      = calc_addr_w(SIZE)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WRITE_PORTS-1:0]          wr_en,
    input  logic [WRITE_PORTS*ADDR_W-1:0]   wr_addr,
    input  logic [WRITE_PORTS*WORDSIZE-1:0] wr_data,
    input  logic [READ_PORTS*ADDR_W-1:0]    rd_addr,
    output logic [READ_PORTS*WORDSIZE-1:0]  rd_data,
    output logic [READ_PORTS-1:0]           rd_busy,
    input  logic                            rsv_en,
    input  logic [ADDR_W-1:0]               rsv_addr,
    output logic [SIZE-1:0]                 busy_vec,
    output logic [$clog2(SIZE+1)-1:0]       busy_count
);

    localparam int CNT_W = $clog2(SIZE + 1);

    logic [WORDSIZE-1:0] regs [1:SIZE-1];

    // Later ports overwrite earlier ones, so the highest-index port wins a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < SIZE; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < SIZE; i++) begin
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                        regs[i] <= wr_data[p*WORDSIZE +: WORDSIZE];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int i = 1; i < SIZE; i++) begin
                if (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    rd_data[p*WORDSIZE +: WORDSIZE] = regs[i];
                end
            end
            rd_busy[p] = busy_vec[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (rd_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)) begin
                for (int q = 0; q < WRITE_PORTS; q++) begin
                    if (wr_en[q] && wr_addr[q*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W]) begin
                        rd_data[p*WORDSIZE +: WORDSIZE] = wr_data[q*WORDSIZE +: WORDSIZE];
                        rd_busy[p] = rsv_en && (rsv_addr == rd_addr[p*ADDR_W +: ADDR_W]);
                    end
                end
            end
`endif
        end
    end

    regfile_scoreboard #(
        .SIZE        (SIZE),
        .WRITE_PORTS (WRITE_PORTS),
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_vec   (busy_vec),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with two read and two write ports.
module tb_regfile_multiport;

    localparam int W  = 64;
    localparam int N  = 32;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [WP-1:0]     wr_en;
    logic [WP*AW-1:0]  wr_addr;
    logic [WP*W-1:0]   wr_data;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP*W-1:0]   rd_data;
    logic [RP-1:0]     rd_busy;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [N-1:0]      busy_vec;
    logic [5:0]        busy_count;

    int total = 0;
    int bad   = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_multiport #(
        .WORDSIZE    (W),
        .SIZE        (N),
        .READ_PORTS  (RP),
        .WRITE_PORTS (WP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_vec   (busy_vec),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*W +: W]   = d;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;

        // Reset discards a concurrent write and reserve
        wr(0, 5'd4, 64'hABCD);
        rsv(5'd6);
        tick();
        reset = 1'b0;
        idle();
        for (int a = 0; a < N; a++) begin
            rd(AW'(a), AW'(N - 1 - a));
            chk($sformatf("rst_rd0_x%0d", a), rd_data[0 +: W], 64'd0);
            chk($sformatf("rst_rd1_x%0d", N - 1 - a), rd_data[W +: W], 64'd0);
            chk($sformatf("rst_busy_x%0d", a), {62'd0, rd_busy}, 64'd0);
        end
        chk("rst_count", {58'd0, busy_count}, 64'd0);
        chk("rst_vec", {32'd0, busy_vec}, 64'd0);

        // Basic write, then a write to x0 that must be ignored
        wr(0, 5'd5, 64'hDEAD_BEEF_0123_4567);
        tick();
        idle();
        rd(5'd5, 5'd0);
        chk("wr_x5", rd_data[0 +: W], 64'hDEAD_BEEF_0123_4567);
        wr(1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        idle();
        rd(5'd0, 5'd5);
        chk("wr_x0_rd0", rd_data[0 +: W], 64'd0);
        chk("x5_rd1", rd_data[W +: W], 64'hDEAD_BEEF_0123_4567);

        // Two ports hit x7 in one cycle: port 1 wins
        wr(0, 5'd7, 64'h11);
        wr(1, 5'd7, 64'h22);
        tick();
        idle();
        rd(5'd5, 5'd7);
        chk("collide_x7", rd_data[W +: W], 64'h22);
        chk("x5_kept", rd_data[0 +: W], 64'hDEAD_BEEF_0123_4567);

        // Reserve x0 is ignored
        rsv(5'd0);
        tick();
        idle();
        rd(5'd0, 5'd0);
        chk("rsv_x0_vec", {32'd0, busy_vec}, 64'd0);
        chk("rsv_x0_busy", {62'd0, rd_busy}, 64'd0);

        // Reserve / release sequence on x9
        rsv(5'd9);
        tick();
        idle();
        rd(5'd9, 5'd7);
        chk("rsv_x9_busy", {62'd0, rd_busy}, 64'd1);
        chk("rsv_x9_count", {58'd0, busy_count}, 64'd1);
        wr(0, 5'd9, 64'h99);
        rsv(5'd9);
        tick();
        idle();
        rd(5'd9, 5'd7);
        chk("rsv_wr_x9_busy", {62'd0, rd_busy}, 64'd1);
        chk("rsv_wr_x9_data", rd_data[0 +: W], 64'h99);
        chk("rsv_wr_x9_count", {58'd0, busy_count}, 64'd1);
        wr(1, 5'd9, 64'hAA);
        tick();
        idle();
        rd(5'd9, 5'd7);
        chk("rel_x9_busy", {62'd0, rd_busy}, 64'd0);
        chk("rel_x9_count", {58'd0, busy_count}, 64'd0);
        chk("rel_x9_data", rd_data[0 +: W], 64'hAA);

        // Writing a register that was never reserved leaves it idle
        wr(0, 5'd10, 64'h10);
        tick();
        idle();
        rd(5'd10, 5'd10);
        chk("wr_idle_busy", {62'd0, rd_busy}, 64'd0);

        // Several reservations, then reset in the middle of a write
        wr(0, 5'd4, 64'h4444);
        tick();
        idle();
        rsv(5'd3);
        tick();
        rsv(5'd4);
        tick();
        rsv(5'd5);
        tick();
        idle();
        rd(5'd3, 5'd5);
        chk("multi_vec", {32'd0, busy_vec}, 64'h38);
        chk("multi_count", {58'd0, busy_count}, 64'd3);
        chk("multi_rdbusy", {62'd0, rd_busy}, 64'd3);
        reset = 1'b1;
        wr(0, 5'd4, 64'h44);
        tick();
        reset = 1'b0;
        idle();
        rd(5'd4, 5'd5);
        chk("rst2_vec", {32'd0, busy_vec}, 64'd0);
        chk("rst2_count", {58'd0, busy_count}, 64'd0);
        chk("rst2_x4", rd_data[0 +: W], 64'd0);
        chk("rst2_x5", rd_data[W +: W], 64'd0);

        // Same-cycle read of a register being written
        wr(0, 5'd12, 64'h33);
        tick();
        idle();
        rsv(5'd12);
        tick();
        idle();
        wr(1, 5'd12, 64'h55);
        rd(5'd12, 5'd3);
        chk("byp_data", rd_data[0 +: W], BYPASS ? 64'h55 : 64'h33);
        chk("byp_busy", {62'd0, rd_busy}, BYPASS ? 64'd0 : 64'd1);
        chk("byp_other", rd_data[W +: W], 64'd0);
        tick();
        idle();
        rd(5'd12, 5'd3);
        chk("byp_next_data", rd_data[0 +: W], 64'h55);
        chk("byp_next_busy", {62'd0, rd_busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the 2-read/1-write register file.
- Configurable read-port count, write-port count and depth; x0 hardwired to zero; synchronous clear.
- Adds a per-register busy scoreboard (reserve at issue, release at write-back) for the pipelined core's hazard logic.
- Sits between the decode/issue stage (reads, reserves) and the write-back stage (writes).

Parameters:
- WORDSIZE, 64, data width in bits.
- SIZE, 32, number of registers; power of two, >= 2.
- READ_PORTS, 2, number of independent read ports, 1..4.
- WRITE_PORTS, 1, number of write ports, 1..2.
- ADDR_W, $clog2(SIZE), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- wr_en  in  WRITE_PORTS  per-port write enable.
- wr_addr  in  WRITE_PORTS*ADDR_W  write addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- wr_data  in  WRITE_PORTS*WORDSIZE  write data, packed the same way.
- rd_addr  in  READ_PORTS*ADDR_W  read addresses, packed.
- rd_data  out  READ_PORTS*WORDSIZE  read data, packed.
- rd_busy  out  READ_PORTS  busy bit of the register addressed on each read port.
- rsv_en  in  1  reserve request from issue.
- rsv_addr  in  ADDR_W  register to mark busy.
- busy_vec  out  SIZE  full scoreboard.
- busy_count  out  $clog2(SIZE+1)  number of set busy bits.

Behaviour:
- Reset:
  - On a rising edge with reset=1, all registers are cleared to 0 and busy_vec to 0.
  - Writes and reserves in that cycle are discarded.
  - Afterwards rd_data=0, rd_busy=0, busy_count=0.
- Reads:
  - Combinational, zero latency.
  - rd_data[p] = reg[rd_addr[p]].
  - Address 0 always returns 0 with rd_busy 0.
- Writes:
  - Port p with wr_en[p]=1 and wr_addr[p]!=0 updates reg[wr_addr[p]] on the rising edge.
  - The written value is visible on reads in the next cycle (no bypass unless the optional feature is enabled).
- Write collision: two ports writing the same address in one cycle -> the highest-index port wins; no error flag.
- Write-back release:
  - Every effective write clears the busy bit of its address.
  - Writing a register that is not busy is legal; its busy bit stays 0.
- Reserve:
  - rsv_en=1 with rsv_addr!=0 sets busy[rsv_addr] on the edge.
  - Reserving an already-busy register keeps it at 1. No counting; single outstanding producer per register.
- Reserve and release of the same address in the same cycle: reserve wins, busy stays 1. The release belongs to the older producer.
- x0: writes, reserves and releases targeting address 0 are ignored; busy[0] is constant 0.
- busy_count: combinational popcount of busy_vec. Range 0..SIZE-1 because x0 is never busy.
- Out-of-range addresses cannot occur (SIZE is a power of two).
- No other state machine. State consists of SIZE-1 data registers plus SIZE-1 busy flops.

Optional Feature:
- Macro REGFILE_WRITE_BYPASS_EN.
- Defined:
  - If any wr_en[q]=1 with wr_addr[q]==rd_addr[p]!=0, rd_data[p] returns that port's wr_data in the same cycle (highest-index matching port wins).
  - rd_busy[p] reads 0 for that address unless rsv_en targets it in the same cycle.
- Undefined: reads return stored values only; rd_busy reflects stored busy bits only.

Decomposition:
- Package regfile_pkg holds:
  - the ZERO_REG constant (0);
  - a function computing ADDR_W from SIZE;
  - a popcount function;
  - typedef reg_addr_t (logic [ADDR_W-1:0] for the default SIZE).
- One sub-module, regfile_scoreboard: owns busy_vec, the reserve/release priority and busy_count.
- The data array and read muxes stay in the top module.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_count=0.
- Write 0xDEAD_BEEF_0123_4567 to x5, read x5 the next cycle -> that value. Write 0xFFFF... to x0 -> x0 still reads 0.
- WRITE_PORTS=2, both ports write x7 (0x11, 0x22) in the same cycle -> x7 reads 0x22.
- Reserve x9 -> rd_busy=1 and busy_count=1. Next cycle, write x9 and reserve x9 together -> busy stays 1, data updated. Write x9 alone -> busy 0, count 0.
- Reserve x3, x4, x5 in successive cycles, then assert reset during a write to x4 -> all busy bits 0, x4 reads 0.
- With REGFILE_WRITE_BYPASS_EN, write 0x55 to x12 while reading x12 -> rd_data=0x55 in the same cycle. Without the macro -> old value in that cycle, 0x55 the next.
